pen_hit_capture: RTL and testbench

//  Light-pen detector stage downstream of the LED matrix scan driver. Correlates the async pen photodiode

---
 rtl/lightpen_pkg.sv | 17 +
 rtl/onehot8_enc.sv | 20 ++
 rtl/pen_hit_capture.sv | 169 ++++++++++++++++
 tb/tb_pen_hit_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lightpen_pkg.sv
// Shared types and helpers for the light-pen hit capture path.
package lightpen_pkg;

    localparam int unsigned MATRIX_N = 8;
    localparam int unsigned COORD_W  = 3;

    typedef enum logic [0:0] {
        StBlank,
        StInteg
    } pen_state_e;

    // True when exactly one bit is set.
    function automatic logic is_onehot8(input logic [MATRIX_N-1:0] v);
        return (v != '0) && ((v & (v - MATRIX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot8_enc.sv
// One-hot scan line to binary index; valid_o flags a legal one-hot input.
module onehot8_enc
    import lightpen_pkg::*;
(
    input  logic [MATRIX_N-1:0] onehot_i,
    output logic [COORD_W-1:0]  idx_o,
    output logic                valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < MATRIX_N; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | COORD_W'(i);
            end
        end
        valid_o = is_onehot8(onehot_i);
    end

endmodule

// File: rtl/pen_hit_capture.sv
// Correlates the light-pen photodiode with the scanned LED pixel and reports
// pixels that saw enough light during their dwell on a valid/ready port.
module pen_hit_capture
    import lightpen_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned HIT_THRESH   = 1024,
    parameter int unsigned CNT_W        = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MATRIX_N-1:0] led_row,
    input  logic [MATRIX_N-1:0] led_col,
    input  logic                pen_in,
    input  logic                pos_ready,
    input  logic                ovf_clr,
    output logic                pos_valid,
    output logic [COORD_W-1:0]  pos_x,
    output logic [COORD_W-1:0]  pos_y,
    output logic                pos_ovf,
    output logic                pos_err,
    output logic                frame_start
);

    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    logic [MATRIX_N-1:0] row_q, col_q, row_prev_q, col_prev_q;
    logic                pen_meta_q, pen_sync_q;
    pen_state_e          state_q, state_d;
    logic [CNT_W-1:0]    blank_cnt_q, blank_cnt_d, hit_cnt_q, hit_cnt_d;
    logic                dwell_ok_q, dwell_ok_d;
    logic [COORD_W-1:0]  dwell_x_q, dwell_x_d, dwell_y_q, dwell_y_d;
    logic                pos_valid_q, pos_valid_d, pos_ovf_q, pos_ovf_d, pos_err_q, pos_err_d;
    logic [COORD_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                frame_start_q, frame_start_d;

    logic [COORD_W-1:0]  row_idx, col_idx;
    logic                row_v, col_v, chg, hit, hit_reached;

    onehot8_enc u_row_enc (
        .onehot_i (row_q),
        .idx_o    (row_idx),
        .valid_o  (row_v)
    );

    onehot8_enc u_col_enc (
        .onehot_i (col_q),
        .idx_o    (col_idx),
        .valid_o  (col_v)
    );

    assign chg         = {row_q, col_q} != {row_prev_q, col_prev_q};
    assign hit_reached = 32'(hit_cnt_q) >= HIT_THRESH;
    assign hit         = chg && (state_q == StInteg) && hit_reached && dwell_ok_q;

    // Dwell FSM: a position change closes the dwell and latches the new pixel's
    // coordinates/legality so the close can be judged without the old inputs.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        dwell_ok_d  = dwell_ok_q;
        dwell_x_d   = dwell_x_q;
        dwell_y_d   = dwell_y_q;
        if (chg) begin
            state_d     = StBlank;
            blank_cnt_d = '0;
            hit_cnt_d   = '0;
            dwell_ok_d  = row_v && col_v;
            dwell_x_d   = col_idx;
            dwell_y_d   = row_idx;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (blank_cnt_q == BlankLast) begin
                        state_d     = StInteg;
                        blank_cnt_d = '0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + CNT_W'(1);
                    end
                end
                StInteg: begin
                    if (pen_sync_q && (hit_cnt_q != CntMax)) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StBlank;
            endcase
        end
    end

    always_comb begin
        pos_valid_d = pos_valid_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        pos_ovf_d   = pos_ovf_q;
        pos_err_d   = pos_err_q;
        if (ovf_clr) begin
            pos_ovf_d = 1'b0;
            pos_err_d = 1'b0;
        end
        if (hit) begin
            if (!pos_valid_q || pos_ready) begin
                pos_valid_d = 1'b1;
                pos_x_d     = dwell_x_q;
                pos_y_d     = dwell_y_q;
            end else begin
                pos_ovf_d = 1'b1;
            end
        end else if (pos_valid_q && pos_ready) begin
            pos_valid_d = 1'b0;
        end
        if (!row_v || !col_v) begin
            pos_err_d = 1'b1;
        end
        frame_start_d = chg && (row_q == MATRIX_N'(1)) && (col_q == MATRIX_N'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= MATRIX_N'(1);
            col_q         <= MATRIX_N'(1);
            row_prev_q    <= MATRIX_N'(1);
            col_prev_q    <= MATRIX_N'(1);
            pen_meta_q    <= 1'b0;
            pen_sync_q    <= 1'b0;
            state_q       <= StBlank;
            blank_cnt_q   <= '0;
            hit_cnt_q     <= '0;
            dwell_ok_q    <= 1'b0;
            dwell_x_q     <= '0;
            dwell_y_q     <= '0;
            pos_valid_q   <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            pos_ovf_q     <= 1'b0;
            pos_err_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            row_q         <= led_row;
            col_q         <= led_col;
            row_prev_q    <= row_q;
            col_prev_q    <= col_q;
            pen_meta_q    <= pen_in;
            pen_sync_q    <= pen_meta_q;
            state_q       <= state_d;
            blank_cnt_q   <= blank_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            dwell_ok_q    <= dwell_ok_d;
            dwell_x_q     <= dwell_x_d;
            dwell_y_q     <= dwell_y_d;
            pos_valid_q   <= pos_valid_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            pos_ovf_q     <= pos_ovf_d;
            pos_err_q     <= pos_err_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pos_valid   = pos_valid_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign pos_ovf     = pos_ovf_q;
    assign pos_err     = pos_err_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pen_hit_capture.sv
// Bench for pen_hit_capture: directed dwell table, overflow/reset sequences,
// then random dwells checked every cycle against a dwell-level reference model.
module tb_pen_hit_capture;

    localparam int unsigned BLANK  = 4;
    localparam int unsigned THRESH = 8;
    localparam int unsigned CW     = 6;

    logic       clk, rst_n;
    logic [7:0] led_row, led_col;
    logic       pen_in, pos_ready, ovf_clr;
    logic       pos_valid, pos_ovf, pos_err, frame_start;
    logic [2:0] pos_x, pos_y;

    pen_hit_capture #(
        .BLANK_CYCLES (BLANK),
        .HIT_THRESH   (THRESH),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_row     (led_row),
        .led_col     (led_col),
        .pen_in      (pen_in),
        .pos_ready   (pos_ready),
        .ovf_clr     (ovf_clr),
        .pos_valid   (pos_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_ovf     (pos_ovf),
        .pos_err     (pos_err),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec, n_miss;

    // Reference model: expected outputs plus events queued for the next edge.
    logic       m_valid, m_ovf, m_err, m_fs;
    logic [2:0] m_x, m_y;
    logic       p_hit, p_fs, p_err;
    logic [2:0] p_x, p_y;
    logic [7:0] m_prev_row, m_prev_col;
    int         cur_start, k;
    bit         cur_first;
    bit         pen_h [0:16383];

    function automatic bit onehot(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ovf = 0; m_err = 0; m_fs = 0; m_x = 0; m_y = 0;
        p_hit = 0; p_fs = 0; p_err = 0; p_x = 0; p_y = 0;
        m_prev_row = 8'd1; m_prev_col = 8'd1;
        cur_start = 0; cur_first = 1; k = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model, compare after the edge.
    task automatic step(input logic [7:0] row, input logic [7:0] col, input logic pen,
                        input logic rdy, input logic clr);
        int cnt;
        bit drop;
        led_row = row; led_col = col; pen_in = pen; pos_ready = rdy; ovf_clr = clr;
        drop = p_hit && m_valid && !rdy;
        if (p_hit) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_x = p_x; m_y = p_y;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
        if (p_err) m_err = 1; else if (clr) m_err = 0;
        m_fs = p_fs;
        p_hit = 0;
        p_fs  = 0;
        if ({row, col} != {m_prev_row, m_prev_col}) begin
            // Light counts from BLANK cycles into the dwell up to two before its end
            // (two-flop sync delay, the change cycle itself is not integrated).
            cnt = 0;
            for (int i = cur_start + BLANK; i <= k - 2; i++) cnt += int'(pen_h[i]);
            p_hit = !cur_first && onehot(m_prev_row) && onehot(m_prev_col) && cnt >= THRESH;
            p_x = enc(m_prev_col);
            p_y = enc(m_prev_row);
            p_fs = (row == 8'd1) && (col == 8'd1);
            cur_start = k;
            cur_first = 0;
        end
        p_err = !onehot(row) || !onehot(col);
        pen_h[k] = pen;
        m_prev_row = row; m_prev_col = col;
        k++;
        @(posedge clk);
        @(negedge clk);
        check("cycle{valid,x,y,ovf,err,fs}",
              {pos_valid, pos_x, pos_y, pos_ovf, pos_err, frame_start},
              {m_valid, m_x, m_y, m_ovf, m_err, m_fs});
    endtask

    task automatic run_dwell(input logic [7:0] row, input logic [7:0] col, input int len,
                             input int lo, input int hi, input logic rdy);
        for (int i = 0; i < len; i++) step(row, col, (i >= lo) && (i <= hi), rdy, 1'b0);
    endtask

    function automatic logic [7:0] rand_pos();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'h81;
        return 8'd1 << $urandom_range(0, 7);
    endfunction

    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
        int         lo;
        int         hi;
        bit         hit;
        logic [2:0] x;
        logic [2:0] y;
    } dwell_t;

    dwell_t tbl [10];

    initial begin
        logic [7:0] rr, rc;
        int len, dens;
        n_vec = 0; n_miss = 0;
        rst_n = 0; led_row = 8'd1; led_col = 8'd1; pen_in = 0; pos_ready = 1; ovf_clr = 0;
        model_reset();

        tbl[0] = '{8'h01, 8'h01, 0, 19, 0, 3'd0, 3'd0};  // reset dwell, discarded
        tbl[1] = '{8'h04, 8'h10, 0, 19, 1, 3'd4, 3'd2};
        tbl[2] = '{8'h02, 8'h01, 4, 10, 0, 3'd0, 3'd0};  // 7 integrated cycles
        tbl[3] = '{8'h02, 8'h02, 4, 11, 1, 3'd1, 3'd1};  // 8 integrated cycles
        tbl[4] = '{8'h08, 8'h04, 0, 3,  0, 3'd0, 3'd0};  // light only while blanked
        tbl[5] = '{8'h08, 8'h00, 0, 19, 0, 3'd0, 3'd0};  // illegal column
        tbl[6] = '{8'h10, 8'h80, 11, 18, 1, 3'd7, 3'd4};
        tbl[7] = '{8'h01, 8'h01, 1, 0,  0, 3'd0, 3'd0};
        tbl[8] = '{8'h01, 8'h02, 1, 0,  0, 3'd0, 3'd0};
        tbl[9] = '{8'h04, 8'h04, 1, 0,  0, 3'd0, 3'd0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {pos_valid, pos_x, pos_y, pos_ovf, pos_err, frame_start}, 10'd0);
        rst_n = 1;

        for (int e = 0; e < 10; e++) begin
            for (int i = 0; i < 20; i++) begin
                step(tbl[e].row, tbl[e].col, (i >= tbl[e].lo) && (i <= tbl[e].hi), 1'b1, 1'b0);
                if (e > 0 && i == 0) check("fs_idle", frame_start, 1'b0);
                if (e > 0 && i == 1) begin
                    check("hit_valid", pos_valid, tbl[e-1].hit);
                    if (tbl[e-1].hit) check("hit_xy", {pos_x, pos_y}, {tbl[e-1].x, tbl[e-1].y});
                    check("frame_start", frame_start, (tbl[e].row == 8'h01) && (tbl[e].col == 8'h01));
                end
                if (e > 0 && i == 2) check("valid_pulse_end", pos_valid, 1'b0);
            end
        end
        check("err_sticky", pos_err, 1'b1);

        // Back-pressure: second hit dropped, first payload held, ovf sticky until cleared.
        run_dwell(8'h02, 8'h04, 20, 0, 19, 1'b0);
        run_dwell(8'h04, 8'h02, 2, 0, 19, 1'b0);
        check("ovf_first_load", {pos_valid, pos_x, pos_y, pos_ovf}, {1'b1, 3'd2, 3'd1, 1'b0});
        run_dwell(8'h04, 8'h02, 18, 0, 19, 1'b0);
        run_dwell(8'h08, 8'h08, 20, 1, 0, 1'b0);
        check("ovf_held", {pos_valid, pos_x, pos_y, pos_ovf}, {1'b1, 3'd2, 3'd1, 1'b1});
        step(8'h08, 8'h08, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", {pos_valid, pos_ovf, pos_err}, {1'b1, 1'b0, 1'b0});
        step(8'h08, 8'h08, 1'b0, 1'b1, 1'b0);
        check("ovf_drain", pos_valid, 1'b0);

        // Reset mid-integration with a hit pending.
        run_dwell(8'h02, 8'h02, 20, 0, 19, 1'b0);
        run_dwell(8'h04, 8'h04, 12, 0, 19, 1'b0);
        check("pre_reset_valid", pos_valid, 1'b1);
        rst_n = 0;
        #1;
        check("async_reset", {pos_valid, pos_x, pos_y, pos_ovf, pos_err, frame_start}, 10'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Random dwells against the model.
        for (int d = 0; d < 60; d++) begin
            do begin
                rr = rand_pos();
                rc = rand_pos();
            end while ({rr, rc} == {m_prev_row, m_prev_col});
            len  = $urandom_range(6, 26);
            dens = $urandom_range(0, 100);
            for (int i = 0; i < len; i++) begin
                step(rr, rc, $urandom_range(0, 99) < dens, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 24) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
